// File: rtl/pipelined_control_unit_pkg.sv
// Shared decode constants, ALU encodings and pipeline control bundles
// for the pipelined LEGv8 control unit.
package pipelined_control_unit_pkg;

  localparam int OP_W_C     = 11;
  localparam int ALUCTL_W_C = 4;
  localparam int ZERO_REG_C = 31;

  localparam logic [10:0] OP_LDUR     = 11'b11111000010;
  localparam logic [10:0] OP_STUR     = 11'b11111000000;
  localparam logic [10:0] OP_ADD      = 11'b10001011000;
  localparam logic [10:0] OP_SUB      = 11'b11001011000;
  localparam logic [10:0] OP_AND      = 11'b10001010000;
  localparam logic [10:0] OP_ORR      = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
  localparam logic [8:0]  OP_MOVZ_PFX = 9'b110100101;

  typedef enum logic [1:0] {
    ALUOP_MEM  = 2'b00,
    ALUOP_BR   = 2'b01,
    ALUOP_R    = 2'b10,
    ALUOP_MOVZ = 2'b11
  } aluop_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef struct packed {
    logic [ALUCTL_W_C-1:0] alucontrol;
    logic                  alusrc;
    logic                  movz;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } id_ex_ctrl_t;

  function automatic logic [ALUCTL_W_C-1:0] alu_control(input aluop_e op, input logic [10:0] opc);
    logic [ALUCTL_W_C-1:0] ctl;
    ctl = ALU_ADD;
    case (op)
      ALUOP_MEM:  ctl = ALU_ADD;
      ALUOP_BR:   ctl = ALU_PASSB;
      ALUOP_MOVZ: ctl = ALU_PASSB;
      ALUOP_R: begin
        case (opc)
          OP_AND:  ctl = ALU_AND;
          OP_ORR:  ctl = ALU_ORR;
          OP_SUB:  ctl = ALU_SUB;
          default: ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/pipelined_control_unit_forwarding_unit.sv
// EX-stage forwarding select for one source operand; EX/MEM wins over MEM/WB,
// and the zero register is never forwarded.
module forwarding_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_C,
  parameter int FWD_EN   = 1
) (
  input  logic             regwrite_mem,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             regwrite_wb,
  input  logic [REG_W-1:0] rd_wb,
  input  logic [REG_W-1:0] rs_ex,
  output logic [1:0]       forward
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  // operand source priority select
  always_comb begin
    forward = 2'b00;
    if (FWD_EN == 0) begin
      forward = 2'b00;
    end else if (regwrite_mem && (rd_mem != ZR) && (rd_mem == rs_ex)) begin
      forward = 2'b10;
    end else if (regwrite_wb && (rd_wb != ZR) && (rd_wb == rs_ex)) begin
      forward = 2'b01;
    end else begin
      forward = 2'b00;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined LEGv8 control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, taken-branch flush and EX forwarding.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int OP_W     = OP_W_C,
  parameter int REG_W    = 5,
  parameter int ALUCTL_W = ALUCTL_W_C,
  parameter int ZERO_REG = ZERO_REG_C,
  parameter int HAZ_EN   = 1,
  parameter int FWD_EN   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     instr_id,
  input  logic [REG_W-1:0]    rn_id,
  input  logic [REG_W-1:0]    rm_id,
  input  logic [REG_W-1:0]    rt_id,
  input  logic                branch_taken_mem,
  output logic                reg2loc_id,
  output logic                stall_id,
  output logic                flush_ifid,
  output logic [ALUCTL_W-1:0] alucontrol_ex,
  output logic                alusrc_ex,
  output logic                movz_ex,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b,
  output logic                memread_mem,
  output logic                memwrite_mem,
  output logic                branch_mem,
  output logic                regwrite_wb,
  output logic                memtoreg_wb,
  output logic [REG_W-1:0]    rd_wb,
  output logic                illegal_id
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic [10:0]       op_s;
  id_ex_ctrl_t       dec_ctrl_s;
  logic              reg2loc_s;
  logic              illegal_s;
  logic [REG_W-1:0]  rs2_id_s;
  logic              stall_s;
  logic              bubble_s;

  id_ex_ctrl_t       id_ex_r;
  logic [REG_W-1:0]  rn_ex_r, rs2_ex_r, rd_ex_r;
  mem_ctrl_t         ex_mem_mem_r;
  wb_ctrl_t          ex_mem_wb_r;
  logic [REG_W-1:0]  rd_mem_r;
  wb_ctrl_t          mem_wb_r;
  logic [REG_W-1:0]  rd_wb_r;

  assign op_s = instr_id[OP_W-1 -: 11];

  // ID opcode decode; anything unrecognised becomes an all-zero NOP
  always_comb begin
    dec_ctrl_s = '0;
    reg2loc_s  = 1'b0;
    illegal_s  = 1'b0;
    if (op_s[10:3] == OP_CBZ_PFX) begin
      reg2loc_s                   = 1'b1;
      dec_ctrl_s.mem.branch       = 1'b1;
      dec_ctrl_s.ex.alucontrol    = alu_control(ALUOP_BR, op_s);
    end else if (op_s[10:2] == OP_MOVZ_PFX) begin
      dec_ctrl_s.ex.alusrc        = 1'b1;
      dec_ctrl_s.ex.movz          = 1'b1;
      dec_ctrl_s.wb.regwrite      = 1'b1;
      dec_ctrl_s.ex.alucontrol    = alu_control(ALUOP_MOVZ, op_s);
    end else begin
      case (op_s)
        OP_LDUR: begin
          dec_ctrl_s.ex.alusrc     = 1'b1;
          dec_ctrl_s.mem.memread   = 1'b1;
          dec_ctrl_s.wb.regwrite   = 1'b1;
          dec_ctrl_s.wb.memtoreg   = 1'b1;
          dec_ctrl_s.ex.alucontrol = alu_control(ALUOP_MEM, op_s);
        end
        OP_STUR: begin
          reg2loc_s                = 1'b1;
          dec_ctrl_s.ex.alusrc     = 1'b1;
          dec_ctrl_s.mem.memwrite  = 1'b1;
          dec_ctrl_s.ex.alucontrol = alu_control(ALUOP_MEM, op_s);
        end
        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
          dec_ctrl_s.wb.regwrite   = 1'b1;
          dec_ctrl_s.ex.alucontrol = alu_control(ALUOP_R, op_s);
        end
        default: illegal_s = 1'b1;
      endcase
    end
  end

  assign rs2_id_s = reg2loc_s ? rt_id : rm_id;

  // load-use detection; a taken branch flushes the load anyway, so no stall
  always_comb begin
    stall_s = 1'b0;
    if ((HAZ_EN != 0) && !branch_taken_mem && id_ex_r.mem.memread &&
        (rd_ex_r != ZR) && ((rd_ex_r == rn_id) || (rd_ex_r == rs2_id_s))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign bubble_s = stall_s | branch_taken_mem;

  // pipeline control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_r      <= '0;
      rn_ex_r      <= '0;
      rs2_ex_r     <= '0;
      rd_ex_r      <= '0;
      ex_mem_mem_r <= '0;
      ex_mem_wb_r  <= '0;
      rd_mem_r     <= '0;
      mem_wb_r     <= '0;
      rd_wb_r      <= '0;
    end else begin
      id_ex_r      <= bubble_s ? id_ex_ctrl_t'('0) : dec_ctrl_s;
      rn_ex_r      <= rn_id;
      rs2_ex_r     <= rs2_id_s;
      rd_ex_r      <= rt_id;
      ex_mem_mem_r <= branch_taken_mem ? mem_ctrl_t'('0) : id_ex_r.mem;
      ex_mem_wb_r  <= branch_taken_mem ? wb_ctrl_t'('0) : id_ex_r.wb;
      rd_mem_r     <= rd_ex_r;
      mem_wb_r     <= ex_mem_wb_r;
      rd_wb_r      <= rd_mem_r;
    end
  end

  forwarding_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG), .FWD_EN(FWD_EN)) u_fwd_a (
    .regwrite_mem (ex_mem_wb_r.regwrite),
    .rd_mem       (rd_mem_r),
    .regwrite_wb  (mem_wb_r.regwrite),
    .rd_wb        (rd_wb_r),
    .rs_ex        (rn_ex_r),
    .forward      (forward_a)
  );

  forwarding_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG), .FWD_EN(FWD_EN)) u_fwd_b (
    .regwrite_mem (ex_mem_wb_r.regwrite),
    .rd_mem       (rd_mem_r),
    .regwrite_wb  (mem_wb_r.regwrite),
    .rd_wb        (rd_wb_r),
    .rs_ex        (rs2_ex_r),
    .forward      (forward_b)
  );

  assign reg2loc_id    = reg2loc_s;
  assign illegal_id    = illegal_s;
  assign stall_id      = stall_s;
  assign flush_ifid    = branch_taken_mem;
  assign alucontrol_ex = ALUCTL_W'(id_ex_r.ex.alucontrol);
  assign alusrc_ex     = id_ex_r.ex.alusrc;
  assign movz_ex       = id_ex_r.ex.movz;
  assign memread_mem   = ex_mem_mem_r.memread;
  assign memwrite_mem  = ex_mem_mem_r.memwrite;
  assign branch_mem    = ex_mem_mem_r.branch;
  assign regwrite_wb   = mem_wb_r.regwrite;
  assign memtoreg_wb   = mem_wb_r.memtoreg;
  assign rd_wb         = rd_wb_r;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Parametrised successor to the single-stage LEGv8 controller.
- Decodes the 11-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use hazard detection (stall/bubble), taken-branch flush and an EX-stage forwarding unit.
- Sits beside the pipelined datapath and replaces per-stage control wiring.

Parameters:
- OP_W, 11: opcode field width.
- REG_W, 5: register address width.
- ALUCTL_W, 4: ALU control width.
- ZERO_REG, 31: XZR index; never forwarded, never causes a hazard.
- HAZ_EN, 1: 0 means stall_id is held at 0.
- FWD_EN, 1: 0 means forward_a/forward_b are held at 2'b00.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr_id  in  OP_W  opcode bits [31:21] of the ID instruction
- rn_id, rm_id, rt_id  in  REG_W  ID register fields ([9:5], [20:16], [4:0])
- branch_taken_mem  in  1  CBZ resolved taken in MEM
- reg2loc_id  out  1  second read-register select (combinational, ID)
- stall_id  out  1  hold PC and IF/ID; ID/EX gets a bubble
- flush_ifid  out  1  zero IF/ID next edge
- alucontrol_ex  out  ALUCTL_W  EX ALU operation
- alusrc_ex, movz_ex  out  1  EX controls
- forward_a, forward_b  out  2  00 regfile, 10 EX/MEM, 01 MEM/WB
- memread_mem, memwrite_mem, branch_mem  out  1  MEM controls
- regwrite_wb, memtoreg_wb  out  1  WB controls
- rd_wb  out  REG_W  WB destination register
- illegal_id  out  1  unrecognised opcode in ID (combinational)

Behaviour:
- Decode (combinational, ID):
  - LDUR 11111000010: alusrc, memtoreg, regwrite, memread; ALUOp 00.
  - STUR 11111000000: reg2loc, alusrc, memwrite; ALUOp 00.
  - CBZ 10110100xxx: reg2loc, branch; ALUOp 01.
  - R-type: regwrite, ALUOp 10. ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - MOVZ 110100101xx: alusrc, regwrite, movz; ALU control 0111.
  - Any other opcode: all controls 0 (NOP), illegal_id=1.
- ALU control encodings:
  - ALUOp 00 gives 0010 (add).
  - ALUOp 01 gives 0111 (pass B).
  - R-type: AND 0000, ORR 0001, ADD 0010, SUB 0110.
- Second source register: rs2_id = reg2loc ? rt_id : rm_id.
- Destination register: rd_id = rt_id for every opcode.
- Pipeline registers: ID/EX holds controls, rn, rs2 and rd. EX/MEM holds mem, wb, rd. MEM/WB holds wb, rd. Each advances every edge.
- Reset: every registered control, register index and rd = 0. All outputs 0 the cycle after reset is sampled. Asserting reset mid-operation kills all in-flight controls the same edge.
- Hazard (combinational):
  - stall_id = HAZ_EN & memread_ex & rd_ex != ZERO_REG & (rd_ex == rn_id | rd_ex == rs2_id).
  - On stall: ID/EX loads all-zero controls; instruction stays in ID; exactly 1 bubble per load-use pair.
- Flush:
  - branch_taken_mem=1 drives flush_ifid=1.
  - Next edge: ID/EX and EX/MEM load zero controls.
  - MEM/WB loads normally; the branch itself writes nothing.
- Flush and stall in the same cycle: flush wins, stall_id forced 0.
- Forwarding (EX, combinational):
  - forward_a = 10 if regwrite_mem & rd_mem != ZERO_REG & rd_mem == rn_ex.
  - Else 01 if regwrite_wb & rd_wb != ZERO_REG & rd_wb == rn_ex.
  - Else 00.
  - forward_b: same rules against rs2_ex. EX/MEM has priority over MEM/WB.
- Latency: each control appears at its stage output exactly 1/2/3 edges after decode (EX/MEM/WB).

Decomposition:
- Shared package: opcode constants, ALUOp encoding, ALU control encodings, ZERO_REG default, and packed struct typedefs ex_ctrl_t, mem_ctrl_t, wb_ctrl_t, id_ex_ctrl_t.
- One sub-module: forwarding_unit (combinational, instantiated twice or dual-output).
- Decode and hazard logic stay inline.

Test Plan:
1. Reset for 2 cycles, then LDUR → all outputs 0 during reset. memread_mem=1 exactly 2 edges after LDUR enters ID; regwrite_wb=1 and memtoreg_wb=1 one edge later.
2. ADD X1,X2,X3 then SUB X4,X1,X5 → SUB in EX: forward_a=10. With one NOP between: forward_a=01.
3. LDUR X9,[X2] then ADD X3,X9,X4 → stall_id=1 for exactly 1 cycle, then 0. ID/EX controls zero that cycle; ADD gets forward_a=01 afterwards.
4. ADD X31,X1,X2 then ORR X5,X31,X6 → forward_a=00, stall_id=0.
5. CBZ taken (branch_taken_mem=1) while LDUR X9 in EX and dependent ADD in ID → stall_id=0, flush_ifid=1. Next cycle memread_mem=0 and alucontrol_ex/alusrc_ex=0.
6. instr_id=00000000000 → illegal_id=1, all downstream controls 0 at EX/MEM/WB. With FWD_EN=0, test 2 gives forward_a=00.
